// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bus of the single-clock FIFO: write/read handshakes, data, status and error flags.
interface sync_fifo_ctrl_if #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Addr_Width = 4
);
  logic                  flush;
  logic                  w_en;
  logic [Data_Width-1:0] w_data;
  logic                  r_en;
  logic [Data_Width-1:0] r_data;
  logic                  full_flag;
  logic                  empty_flag;
  logic                  almost_full;
  logic                  almost_empty;
  logic [Addr_Width:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, w_en, w_data, r_en,
    input  r_data, full_flag, empty_flag, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, w_en, w_data, r_en,
    output r_data, full_flag, empty_flag, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, optional FWFT read,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ctrl #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Addr_Width = 4,
  parameter int unsigned AF_Thresh  = 12,
  parameter int unsigned AE_Thresh  = 4,
  parameter int unsigned FWFT       = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sync_fifo_ctrl_if.slave     bus
);

  localparam int unsigned Depth = 2 ** Addr_Width;
  localparam int unsigned PtrW  = Addr_Width + 1;

  logic [Data_Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  full_c, empty_c;
  logic                  wr_acc_c, rd_acc_c;
  logic [Addr_Width-1:0] wr_addr_c, rd_addr_c;
  logic [Data_Width-1:0] head_c;

  // Flags come from the registered count only, so a same-cycle read never frees a full slot
  assign full_c    = (count_q == PtrW'(Depth));
  assign empty_c   = (count_q == '0);
  assign wr_acc_c  = bus.w_en & ~full_c & ~bus.flush;
  assign rd_acc_c  = bus.r_en & ~empty_c & ~bus.flush;
  assign wr_addr_c = wr_ptr_q[Addr_Width-1:0];
  assign rd_addr_c = rd_ptr_q[Addr_Width-1:0];
  assign head_c    = mem_q[rd_addr_c];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_acc_c) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (wr_acc_c && !rd_acc_c)      count_d = count_q + PtrW'(1);
      else if (rd_acc_c && !wr_acc_c) count_d = count_q - PtrW'(1);
      if (bus.w_en && full_c)  ovf_d = 1'b1;
      if (bus.r_en && empty_c) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc_c) mem_q[wr_addr_c] <= bus.w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.r_data = head_c;
    end else begin : g_std
      logic [Data_Width-1:0] r_data_q;
      always_ff @(posedge clk_i) begin
        if (rst_i)         r_data_q <= '0;
        else if (rd_acc_c) r_data_q <= head_c;
      end
      assign bus.r_data = r_data_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full_flag    = full_c;
  assign bus.empty_flag   = empty_c;
  assign bus.almost_full  = (count_q >= PtrW'(AF_Thresh));
  assign bus.almost_empty = (count_q <= PtrW'(AE_Thresh));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: standard-read instance plus an FWFT instance (Depth=4).
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.Data_Width(8), .Addr_Width(2)) s_if ();
  sync_fifo_ctrl_if #(.Data_Width(8), .Addr_Width(2)) f_if ();

  sync_fifo_ctrl #(.Data_Width(8), .Addr_Width(2), .AF_Thresh(3), .AE_Thresh(1), .FWFT(0))
    u_std (.clk_i(clk), .rst_i(rst), .bus(s_if));
  sync_fifo_ctrl #(.Data_Width(8), .Addr_Width(2), .AF_Thresh(3), .AE_Thresh(1), .FWFT(1))
    u_fwft (.clk_i(clk), .rst_i(rst), .bus(f_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.flush = 0; s_if.w_en = 0; s_if.r_en = 0; s_if.w_data = 8'h00;
    f_if.flush = 0; f_if.w_en = 0; f_if.r_en = 0; f_if.w_data = 8'h00;
  endtask

  task automatic wr(input logic [7:0] d);
    s_if.w_en = 1; s_if.w_data = d; tick(); s_if.w_en = 0;
  endtask

  task automatic rd();
    s_if.r_en = 1; tick(); s_if.r_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    n_cmp++; if (s_if.count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", s_if.count); end
    n_cmp++; if (s_if.empty_flag !== 1'b1 || s_if.full_flag !== 1'b0) begin n_bad++; $display("FAIL rst_empty_full got %b%b exp 10", s_if.empty_flag, s_if.full_flag); end
    n_cmp++; if (s_if.almost_empty !== 1'b1 || s_if.almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_almost got %b%b exp 10", s_if.almost_empty, s_if.almost_full); end
    n_cmp++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b%b exp 00", s_if.overflow, s_if.underflow); end
    n_cmp++; if (s_if.r_data !== 8'h00) begin n_bad++; $display("FAIL rst_rdata got %h exp 00", s_if.r_data); end
  endtask

  task automatic test_fill();
    logic [2:0] c;
    for (int i = 0; i < 4; i++) begin
      wr(8'hA1 + 8'(i));
      c = 3'(i + 1);
      n_cmp++; if (s_if.count !== c) begin n_bad++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, s_if.count, c); end
      n_cmp++; if (s_if.almost_empty !== (c <= 3'd1)) begin n_bad++; $display("FAIL fill_ae[%0d] got %b exp %b", i, s_if.almost_empty, c <= 3'd1); end
      n_cmp++; if (s_if.almost_full !== (c >= 3'd3)) begin n_bad++; $display("FAIL fill_af[%0d] got %b exp %b", i, s_if.almost_full, c >= 3'd3); end
      n_cmp++; if (s_if.full_flag !== (c == 3'd4)) begin n_bad++; $display("FAIL fill_full[%0d] got %b exp %b", i, s_if.full_flag, c == 3'd4); end
    end
    wr(8'hA5);
    n_cmp++; if (s_if.overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf got %b exp 1", s_if.overflow); end
    n_cmp++; if (s_if.count !== 3'd4) begin n_bad++; $display("FAIL fill_ovf_count got %0d exp 4", s_if.count); end
  endtask

  task automatic test_drain();
    s_if.r_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (s_if.r_data !== 8'hA1 + 8'(i)) begin n_bad++; $display("FAIL drain_data[%0d] got %h exp %h", i, s_if.r_data, 8'hA1 + 8'(i)); end
      n_cmp++; if (s_if.count !== 3'(3 - i)) begin n_bad++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, s_if.count, 3 - i); end
    end
    n_cmp++; if (s_if.empty_flag !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b exp 1", s_if.empty_flag); end
    n_cmp++; if (s_if.underflow !== 1'b0) begin n_bad++; $display("FAIL drain_udf_early got %b exp 0", s_if.underflow); end
    tick();
    s_if.r_en = 0;
    n_cmp++; if (s_if.underflow !== 1'b1) begin n_bad++; $display("FAIL drain_udf got %b exp 1", s_if.underflow); end
    n_cmp++; if (s_if.r_data !== 8'hA4) begin n_bad++; $display("FAIL drain_hold got %h exp a4", s_if.r_data); end
  endtask

  task automatic test_simultaneous();
    s_if.flush = 1; tick(); s_if.flush = 0;
    n_cmp++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin n_bad++; $display("FAIL sim_flush_err got %b%b exp 00", s_if.overflow, s_if.underflow); end
    wr(8'h10); wr(8'h11);
    // Count=2: both accepted
    s_if.w_en = 1; s_if.r_en = 1; s_if.w_data = 8'h12; tick();
    n_cmp++; if (s_if.count !== 3'd2) begin n_bad++; $display("FAIL sim_mid_count got %0d exp 2", s_if.count); end
    n_cmp++; if (s_if.r_data !== 8'h10) begin n_bad++; $display("FAIL sim_mid_data got %h exp 10", s_if.r_data); end
    s_if.r_en = 0; s_if.w_data = 8'h13; tick(); s_if.w_data = 8'h14; tick();
    n_cmp++; if (s_if.full_flag !== 1'b1) begin n_bad++; $display("FAIL sim_full got %b exp 1", s_if.full_flag); end
    // Count=4: only the read goes through
    s_if.r_en = 1; s_if.w_data = 8'h15; tick();
    n_cmp++; if (s_if.count !== 3'd3) begin n_bad++; $display("FAIL sim_full_count got %0d exp 3", s_if.count); end
    n_cmp++; if (s_if.overflow !== 1'b1) begin n_bad++; $display("FAIL sim_full_ovf got %b exp 1", s_if.overflow); end
    n_cmp++; if (s_if.r_data !== 8'h11) begin n_bad++; $display("FAIL sim_full_data got %h exp 11", s_if.r_data); end
    s_if.w_en = 0;
    for (int i = 0; i < 3; i++) tick();
    s_if.r_en = 0;
    n_cmp++; if (s_if.r_data !== 8'h14 || s_if.count !== 3'd0) begin n_bad++; $display("FAIL sim_drain got %h/%0d exp 14/0", s_if.r_data, s_if.count); end
    s_if.flush = 1; tick(); s_if.flush = 0;
    // Count=0: only the write goes through
    s_if.w_en = 1; s_if.r_en = 1; s_if.w_data = 8'h16; tick();
    s_if.w_en = 0; s_if.r_en = 0;
    n_cmp++; if (s_if.count !== 3'd1) begin n_bad++; $display("FAIL sim_empty_count got %0d exp 1", s_if.count); end
    n_cmp++; if (s_if.underflow !== 1'b1) begin n_bad++; $display("FAIL sim_empty_udf got %b exp 1", s_if.underflow); end
    n_cmp++; if (s_if.r_data !== 8'h14) begin n_bad++; $display("FAIL sim_empty_hold got %h exp 14", s_if.r_data); end
    rd();
    n_cmp++; if (s_if.r_data !== 8'h16) begin n_bad++; $display("FAIL sim_empty_read got %h exp 16", s_if.r_data); end
  endtask

  task automatic test_wrap();
    s_if.flush = 1; tick(); s_if.flush = 0;
    for (int i = 0; i < 11; i++) begin
      wr(8'(i));
      n_cmp++; if (s_if.count !== 3'd1) begin n_bad++; $display("FAIL wrap_count_w[%0d] got %0d exp 1", i, s_if.count); end
      rd();
      n_cmp++; if (s_if.r_data !== 8'(i) || s_if.count !== 3'd0) begin n_bad++; $display("FAIL wrap_read[%0d] got %h/%0d exp %h/0", i, s_if.r_data, s_if.count, 8'(i)); end
    end
  endtask

  task automatic test_flush_rst();
    wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34); wr(8'h35); rd();
    n_cmp++; if (s_if.count !== 3'd3 || s_if.overflow !== 1'b1) begin n_bad++; $display("FAIL fl_setup got %0d/%b exp 3/1", s_if.count, s_if.overflow); end
    s_if.flush = 1; s_if.w_en = 1; s_if.w_data = 8'h77; tick();
    s_if.flush = 0; s_if.w_en = 0;
    n_cmp++; if (s_if.count !== 3'd0 || s_if.empty_flag !== 1'b1) begin n_bad++; $display("FAIL fl_empty got %0d/%b exp 0/1", s_if.count, s_if.empty_flag); end
    n_cmp++; if (s_if.overflow !== 1'b0) begin n_bad++; $display("FAIL fl_ovf got %b exp 0", s_if.overflow); end
    n_cmp++; if (s_if.r_data !== 8'h31) begin n_bad++; $display("FAIL fl_hold got %h exp 31", s_if.r_data); end
    wr(8'h40); rd();
    n_cmp++; if (s_if.r_data !== 8'h40 || s_if.count !== 3'd0) begin n_bad++; $display("FAIL fl_no77 got %h/%0d exp 40/0", s_if.r_data, s_if.count); end
    wr(8'h50); wr(8'h51); wr(8'h52);
    rst = 1; s_if.r_en = 1; tick(); rst = 0; s_if.r_en = 0;
    n_cmp++; if (s_if.count !== 3'd0 || s_if.empty_flag !== 1'b1 || s_if.full_flag !== 1'b0) begin n_bad++; $display("FAIL rst2_state got %0d/%b/%b exp 0/1/0", s_if.count, s_if.empty_flag, s_if.full_flag); end
    n_cmp++; if (s_if.almost_empty !== 1'b1 || s_if.almost_full !== 1'b0) begin n_bad++; $display("FAIL rst2_almost got %b%b exp 10", s_if.almost_empty, s_if.almost_full); end
    n_cmp++; if (s_if.r_data !== 8'h00 || s_if.underflow !== 1'b0 || s_if.overflow !== 1'b0) begin n_bad++; $display("FAIL rst2_data_err got %h/%b%b exp 00/00", s_if.r_data, s_if.overflow, s_if.underflow); end
  endtask

  task automatic test_fwft();
    f_if.w_en = 1; f_if.w_data = 8'h5C; tick(); f_if.w_en = 0;
    n_cmp++; if (f_if.empty_flag !== 1'b0) begin n_bad++; $display("FAIL fwft_empty got %b exp 0", f_if.empty_flag); end
    n_cmp++; if (f_if.r_data !== 8'h5C) begin n_bad++; $display("FAIL fwft_head got %h exp 5c", f_if.r_data); end
    f_if.w_en = 1; f_if.w_data = 8'h6D; tick(); f_if.w_en = 0;
    n_cmp++; if (f_if.r_data !== 8'h5C || f_if.count !== 3'd2) begin n_bad++; $display("FAIL fwft_hold got %h/%0d exp 5c/2", f_if.r_data, f_if.count); end
    f_if.r_en = 1; tick(); f_if.r_en = 0;
    n_cmp++; if (f_if.r_data !== 8'h6D || f_if.count !== 3'd1) begin n_bad++; $display("FAIL fwft_next got %h/%0d exp 6d/1", f_if.r_data, f_if.count); end
    f_if.r_en = 1; tick(); f_if.r_en = 0;
    n_cmp++; if (f_if.empty_flag !== 1'b1 || f_if.underflow !== 1'b0) begin n_bad++; $display("FAIL fwft_drain got %b/%b exp 1/0", f_if.empty_flag, f_if.underflow); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_flush_rst();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO. It is the same-domain counterpart of the dual-clock FIFO and is used wherever producer and consumer share a clock. It generalises the FIFO in several ways: configurable data width and depth, a fill-level output, programmable almost-full and almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
Parameters:
- Data_Width, default 8: width of each stored word.
- Addr_Width, default 4: address width. Depth = 2**Addr_Width.
- AF_Thresh, default 12: Almost_Full asserts when Count >= AF_Thresh. Legal range is 1..Depth.
- AE_Thresh, default 4: Almost_Empty asserts when Count <= AE_Thresh. Legal range is 0..AF_Thresh-1.
- FWFT, default 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- Clk  in  1  single clock; all logic is on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Flush  in  1  synchronous empty request.
- W_En  in  1  write request.
- W_Data  in  Data_Width  write data.
- R_En  in  1  read request.
- R_Data  out  Data_Width  read data.
- Full_Flag  out  1  Count == Depth.
- Empty_Flag  out  1  Count == 0.
- Almost_Full  out  1  Count >= AF_Thresh.
- Almost_Empty  out  1  Count <= AE_Thresh.
- Count  out  Addr_Width+1  number of stored words, range 0..Depth.
- Overflow  out  1  sticky; set by a write request while full.
- Underflow  out  1  sticky; set by a read request while empty.

## Operation
- Storage is Depth x Data_Width. Memory contents are not reset.
- Write and read pointers are binary and Addr_Width+1 bits wide, so full and empty are distinguished by the MSB. The pointers wrap modulo 2*Depth; the memory address is the lower Addr_Width bits.
- A write is accepted when W_En=1 and Full_Flag=0. A read is accepted when R_En=1 and Empty_Flag=0.
- Flags reflect the registered Count as it stands in the current cycle:
  - A read in the same cycle never frees a slot for a write while full.
  - A write in the same cycle never makes data readable while empty.
- Count update: +1 on a write only, -1 on a read only, unchanged when both or neither are accepted.
- Overflow is set at the edge where W_En=1 and Full_Flag=1. The rejected write leaves memory, pointers and Count unchanged.
- Underflow is set at the edge where R_En=1 and Empty_Flag=1. The rejected read leaves pointers, Count and R_Data unchanged.
- Overflow and Underflow clear only on Rst or Flush.
- Flush: at the next edge, both pointers go to 0, Count goes to 0, and Overflow/Underflow clear. Flush has priority over W_En and R_En in the same cycle; both requests are dropped and no error is flagged. R_Data holds its value.
- Standard mode (FWFT=0): R_Data is a register loaded with the head word on an accepted read. Otherwise it holds.
- FWFT mode (FWFT=1): R_Data shows the head word whenever Empty_Flag=0. R_En consumes the head, and the next word appears after the edge. R_Data is unspecified while Empty_Flag=1.
- Priority order: Rst > Flush > read/write.

## Timing
- Reset values, at the edge after Rst=1: Count=0, Empty_Flag=1, Full_Flag=0, Almost_Empty=1, Almost_Full=0, Overflow=0, Underflow=0, R_Data=0, pointers=0.
- Rst asserted mid-operation discards all contents and drops any same-cycle W_En, R_En or Flush.
- Count, the error flags and the pointers are registered. Full_Flag, Empty_Flag, Almost_Full and Almost_Empty decode combinationally from Count, so they change 1 cycle after the causing edge.
- Write-to-visible latency is 1 cycle: a word written at edge N is readable (Empty_Flag=0) in the cycle after N.
- Standard-mode read latency is 1 cycle: R_En accepted at edge N gives the word on R_Data after edge N.
- Sustained throughput is 1 write and 1 read per cycle.

## Test plan
All scenarios use Data_Width=8, Addr_Width=2 (Depth=4), AF_Thresh=3, AE_Thresh=1, unless stated otherwise.
- Fill: Rst, then write 0xA1..0xA4 on consecutive cycles.
  - Count steps 1,2,3,4.
  - Almost_Empty drops when Count=2. Almost_Full rises when Count=3. Full_Flag rises when Count=4.
  - A fifth write of 0xA5 is dropped: Overflow=1, Count stays 4.
- Drain (FWFT=0): continue from the fill and assert R_En for 5 cycles.
  - R_Data shows 0xA1..0xA4, each one cycle after its accept.
  - Empty_Flag=1 after the fourth read.
  - The fifth read sets Underflow=1; R_Data holds 0xA4.
- Simultaneous requests:
  - At Count=2 with W_En=R_En=1: Count stays 2.
  - At Count=4 with both: only the read is accepted, Count=3, Overflow set.
  - At Count=0 with both: only the write is accepted, Count=1, Underflow set.
- Wrap-around: run 11 alternating write/read pairs with data 0x00..0x0A.
  - Pointers wrap past 2*Depth.
  - Read order matches write order and Count never exceeds 1.
- Flush and Rst:
  - At Count=3 with Overflow=1, assert Flush with W_En=1 and W_Data=0x77. Next cycle: Count=0, Empty_Flag=1, Overflow=0, and 0x77 is never read.
  - Refill to 3 and assert Rst with R_En=1. All outputs take their reset values.
- FWFT=1:
  - Write 0x5C into an empty FIFO. The next cycle has Empty_Flag=0 and R_Data=0x5C without any R_En.
  - Write 0x6D, then pulse R_En. R_Data=0x6D after the edge.
